// File: rtl/core_pkg.sv
// Shared decode/execute definitions: ALU op encoding, opcode and funct fields,
// the decoded-instruction payload and the ALU-subset decoder.
package core_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Decoded control payload handed from ID to EX.
  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                rs2_imm;
    logic [XLEN-1:0]     imm;
    logic [REG_AW-1:0]   rd;
    logic                rd_we;
    logic                illegal;
  } dec_t;

  // ALU-subset decoder; anything unsupported yields illegal with zeroed controls.
  function automatic dec_t decode(input logic [XLEN-1:0] instr);
    dec_t                d;
    logic [ALU_OP_W-1:0] op;
    logic                f3_ok;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    opcode = instr[6:0];
    funct3 = instr[14:12];
    funct7 = instr[31:25];
    d      = '0;
    d.rd   = instr[11:7];
    op     = ALU_ADD;
    f3_ok  = 1'b1;
    case (funct3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_XOR:     op = ALU_XOR;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    f3_ok = 1'b0;
    endcase
    if (opcode == OPC_OP_IMM && f3_ok) begin
      d.alu_op  = op;
      d.rs2_imm = 1'b1;
      d.imm     = {{20{instr[31]}}, instr[31:20]};
    end else if (opcode == OPC_OP && f3_ok && funct7 == F7_BASE) begin
      d.alu_op = op;
    end else if (opcode == OPC_OP && funct3 == F3_ADD_SUB && funct7 == F7_ALT) begin
      d.alu_op = ALU_SUB;
    end else begin
      d.illegal = 1'b1;
    end
    d.rd_we = !d.illegal && (d.rd != '0);
    return d;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Architectural register file, 32 x 32.
// Ports: clk, rst_n (async, active-low, clears all entries);
//        raddr1/raddr2 -> rdata1_c/rdata2_c (combinational reads, x0 reads 0);
//        we/waddr/wdata synchronous write port (writes to x0 ignored).
module regfile
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1_c,
  output logic [XLEN-1:0]   rdata2_c,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  localparam int unsigned NREGS = 32;

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  // Write port.
  always_comb begin
    mem_d = mem_q;
    if (we && waddr != '0) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata1_c = (raddr1 == '0) ? '0 : mem_q[raddr1];
  assign rdata2_c = (raddr2 == '0) ? '0 : mem_q[raddr2];

endmodule

// File: rtl/id_stage.sv
// Decode / operand-fetch stage between fetch and EX.
// Ports: clk, rst_n (async, active-low); flush drops held and offered instr;
//        in_valid/in_ready/in_instr input handshake (in_ready combinational);
//        wb_we/wb_rd/wb_data register-file writeback;
//        out_valid/out_ready output handshake plus registered operands,
//        immediate, ALU op, rs2/imm select, rd, rd_we and illegal flag.
module id_stage
  import core_pkg::*;
#(
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_instr,
  input  logic                wb_we,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_rs1_data,
  output logic [XLEN-1:0]     out_rs2_data,
  output logic [XLEN-1:0]     out_imm,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic                out_alu_rs2_imm,
  output logic [REG_AW-1:0]   out_rd,
  output logic                out_rd_we,
  output logic                out_illegal
);

  logic [REG_AW-1:0] rs1, rs2;
  logic [XLEN-1:0]   rf_rs1, rf_rs2, rs1_fwd, rs2_fwd;
  logic              accept;
  dec_t              dec;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d;
  dec_t              dec_q, dec_d;

  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign dec = decode(in_instr);

  regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .rdata1_c (rf_rs1),
    .rdata2_c (rf_rs2),
    .we       (wb_we),
    .waddr    (wb_rd),
    .wdata    (wb_data)
  );

  // Same-cycle writeback forwarding into the captured operands.
  assign rs1_fwd = (RF_BYPASS && wb_we && wb_rd == rs1 && rs1 != '0) ? wb_data : rf_rs1;
  assign rs2_fwd = (RF_BYPASS && wb_we && wb_rd == rs2 && rs2 != '0) ? wb_data : rf_rs2;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Output register: load on accept, drain on consume, refresh operands while stalled.
  always_comb begin
    valid_d    = valid_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    dec_d      = dec_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      rs1_data_d = rs1_fwd;
      rs2_data_d = rs2_fwd;
      rs1_addr_d = rs1;
      rs2_addr_d = rs2;
      dec_d      = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q && wb_we && wb_rd != '0) begin
      // A held instruction must not see a stale operand when EX finally takes it.
      if (wb_rd == rs1_addr_q) rs1_data_d = wb_data;
      if (wb_rd == rs2_addr_q) rs2_data_d = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      dec_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      dec_q      <= dec_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_rs1_data    = rs1_data_q;
  assign out_rs2_data    = rs2_data_q;
  assign out_imm         = dec_q.imm;
  assign out_alu_op      = dec_q.alu_op;
  assign out_alu_rs2_imm = dec_q.rs2_imm;
  assign out_rd          = dec_q.rd;
  assign out_rd_we       = dec_q.rd_we;
  assign out_illegal     = dec_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: reset, decode, bypass, stall refresh,
// streaming, illegal decode, flush and x0 handling.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [31:0] out_imm;
  logic [3:0]  out_alu_op;
  logic        out_alu_rs2_imm;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  id_stage #(.RF_BYPASS(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .wb_we           (wb_we),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_rs1_data    (out_rs1_data),
    .out_rs2_data    (out_rs2_data),
    .out_imm         (out_imm),
    .out_alu_op      (out_alu_op),
    .out_alu_rs2_imm (out_alu_rs2_imm),
    .out_rd          (out_rd),
    .out_rd_we       (out_rd_we),
    .out_illegal     (out_illegal)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; idle();
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    vec_cnt++; if (out_rs1_data !== 32'h0 || out_imm !== 32'h0 || out_rd !== 5'd0 || out_alu_op !== 4'd0 || out_rd_we !== 1'b0)
      begin err_cnt++; $display("FAIL reset_fields: rs1=%h imm=%h rd=%0d op=%0d we=%0b want all 0", out_rs1_data, out_imm, out_rd, out_alu_op, out_rd_we); end
  endtask

  task automatic test_addi();
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_0010;
    cyc();
    idle(); in_valid = 1'b1; in_instr = 32'hFFF2_8313;  // ADDI x6,x5,-1
    cyc();
    idle();
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL addi_valid: got %0b want 1", out_valid); end
    vec_cnt++; if (out_rs1_data !== 32'h10) begin err_cnt++; $display("FAIL addi_rs1: got %h want 00000010", out_rs1_data); end
    vec_cnt++; if (out_imm !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL addi_imm: got %h want ffffffff", out_imm); end
    vec_cnt++; if (out_alu_op !== 4'd0 || out_alu_rs2_imm !== 1'b1) begin err_cnt++; $display("FAIL addi_ctl: op=%0d rs2imm=%0b want 0/1", out_alu_op, out_alu_rs2_imm); end
    vec_cnt++; if (out_rd !== 5'd6 || out_rd_we !== 1'b1 || out_illegal !== 1'b0) begin err_cnt++; $display("FAIL addi_rd: rd=%0d we=%0b ill=%0b want 6/1/0", out_rd, out_rd_we, out_illegal); end
    cyc();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL addi_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_sub_bypass();
    in_valid = 1'b1; in_instr = 32'h4020_81B3;  // SUB x3,x1,x2
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hAAAA_0000;
    cyc();
    idle();
    vec_cnt++; if (out_rs1_data !== 32'hAAAA_0000) begin err_cnt++; $display("FAIL sub_bypass_rs1: got %h want aaaa0000", out_rs1_data); end
    vec_cnt++; if (out_rs2_data !== 32'h0) begin err_cnt++; $display("FAIL sub_rs2: got %h want 00000000", out_rs2_data); end
    vec_cnt++; if (out_alu_op !== 4'd1 || out_alu_rs2_imm !== 1'b0 || out_imm !== 32'h0) begin err_cnt++; $display("FAIL sub_ctl: op=%0d rs2imm=%0b imm=%h want 1/0/0", out_alu_op, out_alu_rs2_imm, out_imm); end
    vec_cnt++; if (out_rd !== 5'd3 || out_rd_we !== 1'b1) begin err_cnt++; $display("FAIL sub_rd: rd=%0d we=%0b want 3/1", out_rd, out_rd_we); end
    cyc();
  endtask

  task automatic test_stall_refresh();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0020_C233;  // XOR x4,x1,x2
    cyc();
    in_instr = 32'h0010_0493;  // ADDI x9,x0,1 offered but must not be taken
    vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_in_ready: got %0b want 0", in_ready); end
    vec_cnt++; if (out_rs1_data !== 32'hAAAA_0000 || out_rs2_data !== 32'h0) begin err_cnt++; $display("FAIL stall_load: rs1=%h rs2=%h want aaaa0000/0", out_rs1_data, out_rs2_data); end
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h0000_1234;
    cyc();
    wb_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vec_cnt++; if (out_valid !== 1'b1 || out_rs2_data !== 32'h1234 || out_rs1_data !== 32'hAAAA_0000)
        begin err_cnt++; $display("FAIL stall_refresh%0d: v=%0b rs1=%h rs2=%h want 1/aaaa0000/00001234", i, out_valid, out_rs1_data, out_rs2_data); end
      vec_cnt++; if (out_alu_op !== 4'd4 || out_rd !== 5'd4 || out_alu_rs2_imm !== 1'b0 || out_rd_we !== 1'b1)
        begin err_cnt++; $display("FAIL stall_fields%0d: op=%0d rd=%0d rs2imm=%0b we=%0b want 4/4/0/1", i, out_alu_op, out_rd, out_alu_rs2_imm, out_rd_we); end
      cyc();
    end
    idle(); out_ready = 1'b1;
    #1;
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL stall_release_ready: got %0b want 1", in_ready); end
    cyc();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_consume_once: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    for (int k = 1; k <= 4; k++) begin
      ins = (32'(k) << 20) | 32'h0000_0393;  // ADDI x7,x0,k
      in_valid = 1'b1; in_instr = ins;
      cyc();
      vec_cnt++; if (out_valid !== 1'b1 || out_imm !== 32'(k) || out_rd !== 5'd7)
        begin err_cnt++; $display("FAIL b2b_%0d: v=%0b imm=%h rd=%0d want 1/%h/7", k, out_valid, out_imm, out_rd, 32'(k)); end
    end
    idle();
    cyc();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_end: got %0b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_instr = 32'h0000_0063;  // branch
    cyc();
    vec_cnt++; if (out_illegal !== 1'b1 || out_rd_we !== 1'b0 || out_alu_op !== 4'd0 || out_alu_rs2_imm !== 1'b0 || out_imm !== 32'h0)
      begin err_cnt++; $display("FAIL ill_branch: ill=%0b we=%0b op=%0d rs2imm=%0b imm=%h want 1/0/0/0/0", out_illegal, out_rd_we, out_alu_op, out_alu_rs2_imm, out_imm); end
    in_instr = 32'h4020_E1B3;  // OR x3,x1,x2 with funct7 0100000
    cyc();
    idle();
    vec_cnt++; if (out_illegal !== 1'b1 || out_rd_we !== 1'b0 || out_alu_op !== 4'd0 || out_valid !== 1'b1)
      begin err_cnt++; $display("FAIL ill_or7: ill=%0b we=%0b op=%0d v=%0b want 1/0/0/1", out_illegal, out_rd_we, out_alu_op, out_valid); end
    vec_cnt++; if (out_rs1_data !== 32'hAAAA_0000 || out_rs2_data !== 32'h1234)
      begin err_cnt++; $display("FAIL ill_operands: rs1=%h rs2=%h want aaaa0000/00001234", out_rs1_data, out_rs2_data); end
    cyc();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_instr = 32'h0070_0413;  // ADDI x8,x0,7
    cyc();
    in_instr = 32'h0090_0493;  // ADDI x9,x0,9, dropped by flush
    flush = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'h0000_0055;
    cyc();
    idle();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    cyc();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_no_emit: got %0b want 0", out_valid); end
    in_valid = 1'b1; in_instr = 32'h0005_05B3;  // ADD x11,x10,x0
    cyc();
    idle();
    vec_cnt++; if (out_rs1_data !== 32'h55 || out_rd !== 5'd11) begin err_cnt++; $display("FAIL flush_wb_kept: rs1=%h rd=%0d want 00000055/11", out_rs1_data, out_rd); end
    cyc();
  endtask

  task automatic test_x0();
    in_valid = 1'b1; in_instr = 32'h0050_0013;  // ADDI x0,x0,5
    cyc();
    vec_cnt++; if (out_rd_we !== 1'b0 || out_rd !== 5'd0 || out_imm !== 32'h5 || out_illegal !== 1'b0)
      begin err_cnt++; $display("FAIL x0_rd_we: we=%0b rd=%0d imm=%h ill=%0b want 0/0/5/0", out_rd_we, out_rd, out_imm, out_illegal); end
    idle(); wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
    cyc();
    in_valid = 1'b1; in_instr = 32'h0000_0633;  // ADD x12,x0,x0 with x0 write in same cycle
    cyc();
    idle();
    vec_cnt++; if (out_rs1_data !== 32'h0 || out_rs2_data !== 32'h0) begin err_cnt++; $display("FAIL x0_read: rs1=%h rs2=%h want 0/0", out_rs1_data, out_rs2_data); end
    cyc();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0020_C233;  // XOR x4,x1,x2
    cyc();
    idle();
    vec_cnt++; if (out_valid !== 1'b1 || out_rs1_data !== 32'hAAAA_0000) begin err_cnt++; $display("FAIL rstmid_pre: v=%0b rs1=%h want 1/aaaa0000", out_valid, out_rs1_data); end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++; if (out_valid !== 1'b0 || out_rs1_data !== 32'h0) begin err_cnt++; $display("FAIL rstmid_drop: v=%0b rs1=%h want 0/0", out_valid, out_rs1_data); end
    cyc();
    rst_n = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b1; in_instr = 32'h0020_C233;
    cyc();
    idle();
    vec_cnt++; if (out_rs1_data !== 32'h0 || out_rs2_data !== 32'h0) begin err_cnt++; $display("FAIL rstmid_rf_clear: rs1=%h rs2=%h want 0/0", out_rs1_data, out_rs2_data); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub_bypass();
    test_stall_refresh();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_x0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
